// File: rtl/minterm_pkg.sv
// minterm_pkg: shared types and sizes for the minterm extractor.
package minterm_pkg;
    localparam int NVEC  = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;
    localparam int SC_W  = 4;
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;
endpackage

// File: rtl/minterm_extractor_popcount16.sv
// popcount16: number of set bits in a 16-bit minterm mask.
module popcount16
    import minterm_pkg::*;
(
    input  logic [NVEC-1:0]  vec_i,
    output logic [CNT_W-1:0] cnt_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < NVEC; i++) cnt_o = cnt_o + {{(CNT_W-1){1'b0}}, vec_i[i]};
    end
endmodule

// File: rtl/minterm_extractor.sv
// minterm_extractor: sweeps x,y,w,z through all 16 minterms and records
// each function output into a per-function minterm mask.
module minterm_extractor
    import minterm_pkg::*;
#(
    parameter int NOUT   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NOUT-1:0]        func_in,
    input  logic [NVEC*NOUT-1:0]   exp_mask,
    output logic                   x,
    output logic                   y,
    output logic                   w,
    output logic                   z,
    output logic                   busy,
    output logic                   done,
    output logic [NVEC*NOUT-1:0]   mask,
    output logic [CNT_W*NOUT-1:0]  count,
    output logic [NOUT-1:0]        match
);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SETTLE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVEC - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SC_W-1:0]       sc_q, sc_d;
    logic [NVEC*NOUT-1:0]  mask_q, mask_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sc_d    = sc_q;
        mask_d  = mask_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    sc_d    = '0;
                    mask_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (sc_q == SC_LAST) begin
                    sc_d = '0;
                    for (int f = 0; f < NOUT; f++) mask_d[NVEC*f + int'(idx_q)] = func_in[f];
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    sc_d = sc_q + 1'b1;
                end
            end
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    sc_d    = '0;
                    mask_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sc_q    <= '0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sc_q    <= sc_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {x, y, w, z} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign mask         = mask_q;

    for (genvar g = 0; g < NOUT; g++) begin : g_fn
        popcount16 u_pc (
            .vec_i (mask_q[NVEC*g +: NVEC]),
            .cnt_o (count[CNT_W*g +: CNT_W])
        );
        assign match[g] = mask_q[NVEC*g +: NVEC] == exp_mask[NVEC*g +: NVEC];
    end
endmodule

// File: tb/tb_minterm_extractor.sv
// tb_minterm_extractor: directed sweeps checked every cycle against an
// edge-counting model, plus literal expectations for the SoP masks.
module tb_minterm_extractor;
    localparam int NOUT  = 3;
    localparam int VL    = 2;
    localparam int SWEEP = 16 * VL;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [NOUT-1:0] func_in;
    logic [16*NOUT-1:0] exp_mask;
    logic x, y, w, z, busy, done;
    logic [16*NOUT-1:0] mask;
    logic [5*NOUT-1:0] count;
    logic [NOUT-1:0] match;

    logic start3 = 1'b0;
    logic func3, x3, y3, w3, z3, busy3, done3, match3;
    logic [15:0] mask3;
    logic [4:0] count3;

    int errors = 0, checks = 0, busy_cnt = 0, src_sel = 0;
    logic chk_en = 1'b1;
    logic [15:0] sop_tt [3] = '{16'h5266, 16'h16C5, 16'h20AE};

    always #5 clk = ~clk;

    minterm_extractor #(.NOUT(NOUT), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .func_in(func_in),
        .exp_mask(exp_mask), .x(x), .y(y), .w(w), .z(z), .busy(busy), .done(done),
        .mask(mask), .count(count), .match(match)
    );

    minterm_extractor #(.NOUT(1), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0), .func_in(func3),
        .exp_mask(16'h5266), .x(x3), .y(y3), .w(w3), .z(z3), .busy(busy3), .done(done3),
        .mask(mask3), .count(count3), .match(match3)
    );

    function automatic logic [15:0] src_tt(int sel, int f);
        return sel == 1 ? 16'h0000 : sel == 2 ? 16'hFFFF : sop_tt[f];
    endfunction

    function automatic logic src_bit(int sel, int f, logic [3:0] m);
        logic [15:0] t;
        t = src_tt(sel, f);
        return t[m];
    endfunction

    always_comb begin
        func_in = '0;
        for (int f = 0; f < NOUT; f++) func_in[f] = src_bit(src_sel, f, {x, y, w, z});
    end
    assign func3 = sop_tt[0][{x3, y3, w3, z3}];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
        end
    endtask

    // Model: a sweep is just "edges since start"; n samples taken = edges/VL.
    typedef enum {M_IDLE, M_RUN, M_FIN} mst_e;
    mst_e m_st;
    int m_k;
    logic [15:0] m_tt [NOUT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= M_IDLE;
            m_k  <= 0;
        end else if (m_st == M_RUN) begin
            if (abort) m_st <= M_IDLE;
            else begin
                m_k <= m_k + 1;
                if (m_k + 1 == SWEEP) m_st <= M_FIN;
            end
        end else if (start) begin
            m_st <= M_RUN;
            m_k  <= 0;
            for (int f = 0; f < NOUT; f++) m_tt[f] <= src_tt(src_sel, f);
        end
    end

    function automatic logic [15:0] m_mask(int f);
        logic [16:0] lim;
        if (m_st == M_FIN) return m_tt[f];
        if (m_st == M_IDLE) return 16'h0;
        lim = (17'd1 << (m_k / VL)) - 17'd1;
        return m_tt[f] & lim[15:0];
    endfunction

    function automatic int m_idx();
        if (m_st == M_FIN) return 15;
        if (m_st == M_IDLE) return 0;
        return (m_k / VL) > 15 ? 15 : m_k / VL;
    endfunction

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_st == M_RUN));
            chk("done", 64'(done), 64'(m_st == M_FIN));
            chk("xywz", 64'({x, y, w, z}), 64'(m_idx()));
            for (int f = 0; f < NOUT; f++) begin
                chk("mask", 64'(mask[16*f +: 16]), 64'(m_mask(f)));
                chk("count", 64'(count[5*f +: 5]), 64'($countones(m_mask(f))));
                if (m_st == M_FIN) chk("match", 64'(match[f]), 64'(m_mask(f) == exp_mask[16*f +: 16]));
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            edges++;
            if (done) return;
        end
        chk("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic wait_idx(input int v);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if ({x, y, w, z} == 4'(v)) return;
        end
        chk("idx_timeout", 64'({x, y, w, z}), 64'(v));
    endtask

    initial begin
        int e;
        exp_mask = {16'h20AE, 16'h16C5, 16'h5266};
        #3;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_mask", 64'(mask), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_xywz", 64'({x, y, w, z}), 64'(0));
        #10 rst_n = 1'b1;

        busy_cnt = 0;
        pulse_start();
        wait_done(e);
        chk("sweep_edges", 64'(e), 64'(32));
        chk("busy_cycles", 64'(busy_cnt), 64'(32));
        chk("sop_mask", 64'(mask), 64'(48'h20AE_16C5_5266));
        chk("sop_count", 64'(count), 64'({5'd6, 5'd7, 5'd7}));
        chk("sop_match", 64'(match), 64'(3'b111));
        exp_mask[31:16] = 16'h16C4;
        #1 chk("sop_match_bad", 64'(match), 64'(3'b101));

        src_sel = 1;
        pulse_start();
        chk("restart_done_drop", 64'(done), 64'(0));
        chk("restart_busy", 64'(busy), 64'(1));
        wait_done(e);
        chk("zero_mask", 64'(mask), 64'(0));
        chk("zero_count", 64'(count), 64'(0));
        src_sel = 2;
        pulse_start();
        wait_done(e);
        chk("ones_mask", 64'(mask), 64'(48'hFFFF_FFFF_FFFF));
        chk("ones_count", 64'(count), 64'({5'd16, 5'd16, 5'd16}));

        src_sel = 0;
        exp_mask = {16'h20AE, 16'h16C5, 16'h5266};
        pulse_start();
        wait_idx(7);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_mask", 64'(mask), 64'(0));
        chk("abort_xywz", 64'({x, y, w, z}), 64'(0));
        @(posedge clk); #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        pulse_start();
        wait_idx(3);
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done(e);
        chk("post_abort_mask", 64'(mask), 64'(48'h20AE_16C5_5266));
        chk("post_abort_match", 64'(match), 64'(3'b111));

        pulse_start();
        wait_idx(4);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'(0));

        pulse_start();
        wait_idx(10);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_mask", 64'(mask), 64'(0));
        chk("arst_xywz", 64'({x, y, w, z}), 64'(0));
        #10 rst_n = 1'b1;

        chk_en = 1'b0;
        @(posedge clk); #2 start3 = 1'b1;
        @(posedge clk); #2 start3 = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            chk("s3_xywz", 64'({x3, y3, w3, z3}), 64'((k / 4) > 15 ? 15 : k / 4));
            chk("s3_done", 64'(done3), 64'(k >= 64));
        end
        chk("s3_mask", 64'(mask3), 64'(16'h5266));
        chk("s3_count", 64'(count3), 64'(7));
        chk("s3_match", 64'(match3), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/minterm_extractor.md
Name: minterm_extractor

Overview:
- Sequential truth-table reader for 4-input combinational SoP blocks. It is the inverse of an SoP writer: the SoP writer turns a minterm list into logic, and this block recovers the minterm list from the logic.
- Drives x,y,w,z through minterms 0..15, waits a settle time, and samples up to NOUT function outputs. It then reports a per-function 16-bit minterm mask, a minterm count, and a match against expected masks.
- Sits beside any 4-input SoP module as a self-checking harness/BIST controller.

Parameters:
NOUT, 3, number of function outputs sampled (1..8)
SETTLE, 1, cycles between applying a vector and sampling it (1..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; honoured only in IDLE or DONE
abort  input  1  synchronous cancel of a running sweep
func_in  input  NOUT  sampled outputs of the function under test; bit f = function f
exp_mask  input  16*NOUT  expected minterm masks; bits [16f+15:16f] for function f
x  output  1  drive to DUT, minterm index bit 3
y  output  1  drive to DUT, minterm index bit 2
w  output  1  drive to DUT, minterm index bit 1
z  output  1  drive to DUT, minterm index bit 0
busy  output  1  high while sweeping
done  output  1  high from sweep completion until next start or reset
mask  output  16*NOUT  captured masks; bit 16f+m = function f at minterm m
count  output  5*NOUT  popcount of each mask (0..16)
match  output  NOUT  bit f = (mask f == exp_mask f); valid only while done=1

Behaviour:
- Reset (async, rst_n=0): state IDLE, idx=0 (x=y=w=z=0), sc=0, busy=0, done=0, mask=0. count and match derive from mask, so count=0.
- Reset mid-sweep discards everything immediately. No partial result survives.
- States: IDLE, DRIVE, DONE.
- IDLE to DRIVE on start=1: idx=0, sc=0, mask cleared, busy=1.
- In DRIVE, on each edge:
  - If abort=1: go to IDLE, busy=0, done=0, mask cleared, idx=0. Abort has priority over sampling.
  - Else if sc==SETTLE: mask[16f+idx] <= func_in[f] for all f, sc=0.
    - If idx==15: go to DONE, busy=0, done=1, idx held at 15.
    - Otherwise idx <= idx+1.
  - Else sc <= sc+1.
- Timing: each vector occupies SETTLE+1 cycles. The sweep takes 16*(SETTLE+1) edges after the start edge. For SETTLE=1, done first reads 1 after the 32nd edge following start.
- x,y,w,z come straight from the idx register, MSB = x. They change only on the edge following a sample.
- DONE to DRIVE on start=1: same actions as from IDLE, and done drops on that edge.
- DONE with start=0: outputs hold. abort is ignored in IDLE and DONE.
- start while busy is ignored. start and abort in the same cycle in DRIVE resolve as abort.
- count and match are combinational from mask and exp_mask. match is don't-care when done=0. Benches check it only at done=1.
- func_in is sampled only at sc==SETTLE. Glitches earlier in the window are ignored.

Decomposition:
- Package minterm_pkg:
  - state enum {IDLE, DRIVE, DONE}
  - NVEC=16, IDX_W=4, CNT_W=5
  - SC_W=4 (sized for SETTLE max 15)
- Sub-module popcount16 (16-bit input, 5-bit count, combinational), instantiated NOUT times by generate.
- FSM, idx/sc counters and mask register stay in the top.

Test Plan:
- DUT = the three-function SoP block (C, D, E), NOUT=3, SETTLE=1, start pulse. The sweep must show:
  - busy high for 32 cycles.
  - Mask for function 0: 0x5266, function 1: 0x16C5, function 2: 0x20AE.
  - count = 7,7,6.
  - exp_mask = same values gives match=3'b111 with done=1.
- Same run with exp_mask for function 1 = 0x16C4: match=3'b101.
- func_in tied to 3'b000 and then to 3'b111 (two sweeps using restart from DONE): all masks 0x0000 with count 0, then 0xFFFF with count 16. done must drop on the restart edge.
- SETTLE=3: x,y,w,z step every 4 cycles, 0000 to 1111. done rises 64 edges after start.
- abort asserted at idx=7: next edge gives IDLE, busy=0, done=0, mask=0, xywz=0000. A later start gives a full correct sweep.
- rst_n pulled low asynchronously mid-cycle at idx=10: outputs clear immediately without a clock edge. start during busy has no effect on idx or sc.
